ysyx_23060187_wbu: RTL
======================

Name: ysyx_23060187_wbu

Overview:
Write-back unit between the execute/LSU stage and the general-purpose register file.
- Accepts one retiring instruction per handshake.
- For loads, waits for the memory read response, then aligns and sign/zero-extends the data.
- Drives the register file single write port for exactly one cycle per instruction, plus a retire pulse for the difftest/commit logic.

Parameters:
ADDR_WIDTH, 5, register index width (matches register file)
DATA_WIDTH, 32, datapath width; load alignment logic is defined for 32 only

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
in_valid  in  1  upstream has an instruction to retire
in_ready  out  1  WBU can accept this cycle
in_rd  in  ADDR_WIDTH  destination register
in_rd_wen  in  1  instruction writes rd
in_is_load  in  1  result comes from memory
in_load_fn  in  3  funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
in_addr_lo  in  2  load address bits [1:0]
in_result  in  DATA_WIDTH  ALU/CSR/link result (non-load)
mem_rdata_valid  in  1  memory read data valid (single-cycle pulse)
mem_rdata  in  DATA_WIDTH  naturally aligned 32-bit word containing the load
rf_wen  out  1  register file write enable
rf_waddr  out  ADDR_WIDTH  register file write address
rf_wdata  out  DATA_WIDTH  register file write data
done  out  1  one-cycle retire pulse
err  out  1  one-cycle pulse: misaligned or illegal load, no write

Behaviour:
- Reset: synchronous, active-high. At rst=1 the next state is IDLE and all capture registers clear.
  - Outputs during and after reset: rf_wen=0, rf_waddr=0, rf_wdata=0, done=0, err=0, in_ready=1.
  - Reset in any state, including WAIT_MEM, discards the in-flight instruction with no write and no done.
- States:
  - IDLE: in_ready=1.
  - WAIT_MEM: in_ready=0.
  - WB: in_ready=1.
- Accept: on in_valid && in_ready, capture rd, rd_wen, is_load, load_fn, addr_lo, result.
- Next state after accept:
  - Non-load → WB.
  - Legal, aligned load → WAIT_MEM.
  - Illegal or misaligned load → WB with the error flag set.
- Load legality:
  - load_fn 011/110/111 is illegal.
  - LH/LHU with addr_lo[0]=1 is misaligned.
  - LW with addr_lo≠0 is misaligned.
- WAIT_MEM: hold until mem_rdata_valid=1. That cycle, register the extracted value and go to WB.
- Extraction:
  - Byte = mem_rdata[8*addr_lo +: 8].
  - Half = mem_rdata[16*addr_lo[1] +: 16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
- mem_rdata_valid is ignored in IDLE and WB (no effect, no state change).
- WB (exactly one cycle):
  - done=1.
  - rf_wen=captured rd_wen && rd≠0 && !error.
  - rf_waddr=captured rd; rf_wdata=the selected value.
  - If error: err=1 and rf_wen=0, but done is still 1.
- Outside WB: rf_wen, done and err are 0. rf_waddr/rf_wdata hold their last value.
- Latency from accept to WB:
  - Non-load: 1 cycle.
  - Load: cycles to mem_rdata_valid + 1; a response in the cycle after accept gives WB 2 cycles after accept.
- Back-to-back: accepting in WB is legal, so non-load throughput is 1 instruction/cycle with WB held continuously, each cycle showing the new instruction.
- A load accepted in WB moves to WAIT_MEM.
- Stall rule: upstream holds all in_* stable while in_valid && !in_ready.
- Outputs are registered; no combinational path from in_* to rf_*, done or err.
  - in_ready depends only on state.

Test Plan:
1. rst=1 for 2 cycles, then in_valid=1, rd=5, rd_wen=1, is_load=0, result=0xDEADBEEF → exactly one cycle later: rf_wen=1, waddr=5, wdata=0xDEADBEEF, done=1. Next cycle rf_wen=0.
2. Three back-to-back non-loads, rd=1,2,3, results 0x11,0x22,0x33, in_valid held → in_ready stays 1; WB on three consecutive cycles writes x1=0x11, x2=0x22, x3=0x33.
3. LB addr_lo=3, mem_rdata=0x80FF7F01 returned 4 cycles after accept → in_ready=0 while waiting; then rf_wdata=0xFFFFFF80. Repeat LBU → 0x00000080; LHU addr_lo=2 → 0x000080FF; LH addr_lo=0 → 0x00007F01.
4. LW addr_lo=2, rd=7 → no wait; next cycle err=1, done=1, rf_wen=0. Stray mem_rdata_valid afterwards changes nothing. Same result for load_fn=011.
5. Non-load with rd=0, rd_wen=1, result=0x1234 → done=1, rf_wen=0.
6. LW accepted, rst pulsed in WAIT_MEM, then mem_rdata_valid=1 → no rf_wen, no done; state IDLE, in_ready=1.

Source files
------------

// File: rtl/ysyx_23060187_wbu.sv
// Write-back unit: retires one instruction per handshake, waits for load data,
// aligns/extends it and drives the register file write port for one cycle.
module ysyx_23060187_wbu #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_rd,
    input  logic                  in_rd_wen,
    input  logic                  in_is_load,
    input  logic [2:0]            in_load_fn,
    input  logic [1:0]            in_addr_lo,
    input  logic [DATA_WIDTH-1:0] in_result,
    input  logic                  mem_rdata_valid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  done,
    output logic                  err
);
    typedef enum logic [1:0] {IDLE, WAIT_MEM, WB} state_t;

    state_t                state, state_nxt;
    logic                  accept, load_bad;
    logic [ADDR_WIDTH-1:0] cap_rd, cap_rd_nxt;
    logic                  cap_rd_wen, cap_rd_wen_nxt;
    logic [2:0]            cap_fn, cap_fn_nxt;
    logic [1:0]            cap_lo, cap_lo_nxt;
    logic                  wen_nxt, done_nxt, err_nxt;
    logic [ADDR_WIDTH-1:0] waddr_nxt;
    logic [DATA_WIDTH-1:0] wdata_nxt, load_val;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;

    assign in_ready = (state != WAIT_MEM);
    assign accept   = in_valid && in_ready;

    // Illegal funct3 or a half/word access not on its natural boundary.
    assign load_bad = in_is_load &&
                      ((in_load_fn == 3'b011) || (in_load_fn == 3'b110) || (in_load_fn == 3'b111) ||
                       ((in_load_fn[1:0] == 2'b01) && in_addr_lo[0]) ||
                       ((in_load_fn == 3'b010) && (in_addr_lo != 2'b00)));

    assign byte_sel = mem_rdata[{cap_lo, 3'b000} +: 8];
    assign half_sel = mem_rdata[{cap_lo[1], 4'b0000} +: 16];

    always_comb begin
        load_val = mem_rdata;
        case (cap_fn)
            3'b000:  load_val = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
            3'b001:  load_val = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
            3'b100:  load_val = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
            3'b101:  load_val = {{(DATA_WIDTH-16){1'b0}}, half_sel};
            default: load_val = mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cap_rd     <= '0;
            cap_rd_wen <= 1'b0;
            cap_fn     <= '0;
            cap_lo     <= '0;
            rf_wen     <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_nxt;
            cap_rd     <= cap_rd_nxt;
            cap_rd_wen <= cap_rd_wen_nxt;
            cap_fn     <= cap_fn_nxt;
            cap_lo     <= cap_lo_nxt;
            rf_wen     <= wen_nxt;
            rf_waddr   <= waddr_nxt;
            rf_wdata   <= wdata_nxt;
            done       <= done_nxt;
            err        <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_MEM: if (mem_rdata_valid) state_nxt = WB;
            IDLE, WB: begin
                if (accept) state_nxt = (in_is_load && !load_bad) ? WAIT_MEM : WB;
                else        state_nxt = IDLE;
            end
            default:  state_nxt = IDLE;
        endcase
    end

    // Output registers are loaded one cycle ahead so WB shows them directly.
    always_comb begin
        cap_rd_nxt     = cap_rd;
        cap_rd_wen_nxt = cap_rd_wen;
        cap_fn_nxt     = cap_fn;
        cap_lo_nxt     = cap_lo;
        wen_nxt        = 1'b0;
        done_nxt       = 1'b0;
        err_nxt        = 1'b0;
        waddr_nxt      = rf_waddr;
        wdata_nxt      = rf_wdata;
        if (state == WAIT_MEM) begin
            if (mem_rdata_valid) begin
                done_nxt  = 1'b1;
                wen_nxt   = cap_rd_wen && (cap_rd != '0);
                waddr_nxt = cap_rd;
                wdata_nxt = load_val;
            end
        end else if (accept) begin
            cap_rd_nxt     = in_rd;
            cap_rd_wen_nxt = in_rd_wen;
            cap_fn_nxt     = in_load_fn;
            cap_lo_nxt     = in_addr_lo;
            if (!in_is_load) begin
                done_nxt  = 1'b1;
                wen_nxt   = in_rd_wen && (in_rd != '0);
                waddr_nxt = in_rd;
                wdata_nxt = in_result;
            end else if (load_bad) begin
                done_nxt  = 1'b1;
                err_nxt   = 1'b1;
                waddr_nxt = in_rd;
            end
        end
    end
endmodule
